fault_recovery_controller: RTL
==============================

// Module: fault_recovery_controller
// PURPOSE
//  Supervisory sequencer downstream of fault_detector: consumes its 2-bit state (y) and raw fault_flags.
//  Drives power enable/derate, runs shutdown -> cooldown -> detector-reset -> retry, locks out after MAX_RETRY.
//  Owns mask_reg and feeds it to fault_detector; software writes masks through a one-cycle write strobe.
// PARAMETERS
//  MAX_RETRY        3   consecutive shutdowns before LOCKOUT (>=1)
//  COOLDOWN_CYCLES  20  clocks spent in COOLDOWN (>=1)
//  DET_RST_CYCLES   2   clocks det_reset held high in RETRY (>=1)
//  STABLE_CYCLES    50  clean RUN clocks needed to clear retry_cnt (>=1)
// PORTS
//  clk           in   1   system clock, rising edge
//  reset         in   1   asynchronous, active-high
//  det_state     in   2   fault_detector y: 00 NORMAL, 01 WARNING, 10 FAULT, 11 treated as FAULT
//  fault_flags   in   4   raw flags, bit0 undervoltage, 1 overtemp, 2 overvoltage, 3 overcurrent
//  mask_wr_en    in   1   one-cycle mask write strobe
//  mask_wr_data  in   4   new mask value
//  sw_clear      in   1   one-cycle lockout release
//  mask_reg      out  4   mask to fault_detector
//  power_en      out  1   power stage enable
//  derate        out  1   reduced-output request
//  det_reset     out  1   synchronous reset request to fault_detector
//  lockout       out  1   high in LOCKOUT
//  retry_cnt     out  $clog2(MAX_RETRY+1)  shutdowns since last stable period
//  fault_log     out  4   latched fault cause (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): state RUN, power_en=1, derate=0, det_reset=0, lockout=0, retry_cnt=0, mask_reg=0, fault_log=0, all timers 0.
//  Moore outputs, registered: det_state sampled at edge N -> new state and outputs at edge N+1 (1-cycle latency).
//  RUN:      power_en=1. FAULT -> SHUTDOWN; WARNING -> DERATE; NORMAL increments stable timer,
//            at STABLE_CYCLES consecutive clean cycles retry_cnt<=0 (timer saturates, no wrap). Leaving RUN clears timer.
//  DERATE:   power_en=1, derate=1. NORMAL -> RUN; FAULT -> SHUTDOWN; WARNING stays.
//  SHUTDOWN: single cycle, power_en=0. retry_cnt+1 (saturates at MAX_RETRY).
//            If incremented value == MAX_RETRY -> LOCKOUT else COOLDOWN.
//  COOLDOWN: power_en=0; counts COOLDOWN_CYCLES clocks including entry, then RETRY. det_state ignored.
//  RETRY:    power_en=0, det_reset=1 for DET_RST_CYCLES clocks, then RUN with power_en=1.
//  LOCKOUT:  power_en=0, lockout=1. sw_clear -> retry_cnt<=0, enter COOLDOWN (retry starts fresh). Otherwise stays.
//  sw_clear outside LOCKOUT: ignored (except fault_log, see CONFIGURATION).
//  Mask write: accepted in every state; mask_reg <= mask_wr_data at the edge after the strobe. Same-cycle
//   mask write and state transition both take effect; transition uses the det_state sampled that cycle.
//  Priority in RUN/DERATE: FAULT > WARNING > NORMAL.
//  Reset mid-sequence: any state returns to RUN immediately, retry history and masks lost.
// CONFIGURATION
//  FAULT_LOG_EN defined: on every SHUTDOWN entry, fault_log <= fault_log | (fault_flags & ~mask_reg)
//   using values sampled on the transition edge; sticky; cleared to 0 by sw_clear in any state.
//  FAULT_LOG_EN undefined: fault_log tied to 4'b0000, no log flops.
// STRUCTURE
//  Package fault_pkg: det_state_t enum (NORMAL/WARNING/FAULT), ctrl_state_t enum (RUN, DERATE, SHUTDOWN,
//   COOLDOWN, RETRY, LOCKOUT), flag index constants UNDERVOLTAGE=0, OVERTEMP=1, OVERVOLTAGE=2, OVERCURRENT=3.
//   fault_detector shares det_state_t from this package.
//  Sub-module fault_timer: parameterised load/enable down-counter with done flag, instanced for cooldown,
//   detector-reset hold and stable windows (widths via $clog2(param+1)).
// TESTING
//  1 Reset, det_state=NORMAL 100 clk -> RUN, power_en=1, retry_cnt=0, all other outputs 0.
//  2 det_state=WARNING 5 clk then NORMAL -> derate=1 one cycle after WARNING, 0 one cycle after NORMAL, power_en stays 1.
//  3 det_state=FAULT 1 clk -> power_en=0 next edge, retry_cnt=1, COOLDOWN 20 clk, det_reset=1 exactly 2 clk, power_en=1 after.
//  4 FAULT on each return to RUN, 3 times -> retry_cnt=3, lockout=1, power_en=0 held 200 clk; sw_clear -> retry_cnt=0,
//    COOLDOWN, RETRY, RUN.
//  5 One fault then 50 clean RUN clocks -> retry_cnt 1 -> 0 on 50th; fault at 49th clean clock -> retry_cnt=2.
//  6 mask_wr_en with 4'b0100 during COOLDOWN -> mask_reg=4'b0100 next edge; with FAULT_LOG_EN, fault_flags=4'b1100 at
//    SHUTDOWN entry -> fault_log=4'b1000; sw_clear -> fault_log=0; without macro fault_log stays 0.

Source files
------------

// File: rtl/fault_pkg.sv
// Shared types for the fault supervision path: detector state encoding,
// recovery controller states and fault flag bit positions.
package fault_pkg;

   // Detector state as produced by fault_detector; 2'b11 is read as FAULT.
   typedef enum logic [1:0] {
      NORMAL  = 2'b00,
      WARNING = 2'b01,
      FAULT   = 2'b10
   } det_state_t;

   // Recovery controller sequencing states.
   typedef enum logic [2:0] {
      RUN,
      DERATE,
      SHUTDOWN,
      COOLDOWN,
      RETRY,
      LOCKOUT
   } ctrl_state_t;

   // Bit positions inside fault_flags / mask_reg / fault_log.
   localparam int UNDERVOLTAGE = 0;
   localparam int OVERTEMP     = 1;
   localparam int OVERVOLTAGE  = 2;
   localparam int OVERCURRENT  = 3;

   // Both FAULT encodings (10 and 11) share the upper bit.
   function automatic logic det_is_fault(input logic [1:0] s);
      return s[1];
   endfunction

endpackage

// File: rtl/fault_timer.sv
// Down-counter used for the cooldown, detector-reset hold and stable windows.
// While load is high the counter is primed with CYCLES-1; while en is high it
// counts down to zero and then holds, so done marks the CYCLES-th enabled clock.
module fault_timer #(
   parameter int CYCLES = 1,
   localparam int W = $clog2(CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic done
);

   logic [W-1:0] count;

   // Load has priority over counting; the counter saturates at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= W'(CYCLES - 1);
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/fault_recovery_controller.sv
// Supervisory recovery sequencer behind fault_detector: runs
// shutdown -> cooldown -> detector reset -> retry and locks out after
// MAX_RETRY consecutive shutdowns. Owns the detector fault mask.
// Optional feature: define FAULT_LOG_EN to latch sticky fault causes into
// fault_log; without it fault_log is tied to zero.
module fault_recovery_controller
   import fault_pkg::*;
#(
   parameter int MAX_RETRY       = 3,
   parameter int COOLDOWN_CYCLES = 20,
   parameter int DET_RST_CYCLES  = 2,
   parameter int STABLE_CYCLES   = 50,
   localparam int RW = $clog2(MAX_RETRY + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    det_state,
   input  logic [3:0]    fault_flags,
   input  logic          mask_wr_en,
   input  logic [3:0]    mask_wr_data,
   input  logic          sw_clear,
   output logic [3:0]    mask_reg,
   output logic          power_en,
   output logic          derate,
   output logic          det_reset,
   output logic          lockout,
   output logic [RW-1:0] retry_cnt,
   output logic [3:0]    fault_log
);

   ctrl_state_t   state;
   logic          is_fault;
   logic          is_warning;
   logic          is_normal;
   logic          clean_run;
   logic          cool_done;
   logic          hold_done;
   logic          stable_done;
   logic          shutdown_entry;
   logic [RW-1:0] retry_inc;

   assign is_fault       = det_is_fault(det_state);
   assign is_warning     = (det_state == WARNING);
   assign is_normal      = (det_state == NORMAL);
   assign clean_run      = (state == RUN) && is_normal;
   assign shutdown_entry = ((state == RUN) || (state == DERATE)) && is_fault;
   assign retry_inc      = (retry_cnt == RW'(MAX_RETRY)) ? retry_cnt : retry_cnt + 1'b1;

   // Timers stay primed outside their own state, so entry needs no extra load logic.
   fault_timer #(.CYCLES(COOLDOWN_CYCLES)) u_cooldown_timer (
      .clk   (clk),
      .reset (reset),
      .load  (state != COOLDOWN),
      .en    (state == COOLDOWN),
      .done  (cool_done)
   );

   fault_timer #(.CYCLES(DET_RST_CYCLES)) u_hold_timer (
      .clk   (clk),
      .reset (reset),
      .load  (state != RETRY),
      .en    (state == RETRY),
      .done  (hold_done)
   );

   // Any non-clean cycle or leaving RUN restarts the stable window.
   fault_timer #(.CYCLES(STABLE_CYCLES)) u_stable_timer (
      .clk   (clk),
      .reset (reset),
      .load  (!clean_run),
      .en    (clean_run),
      .done  (stable_done)
   );

   // Recovery sequencer; outputs are updated together with the state they belong to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         power_en  <= 1'b1;
         derate    <= 1'b0;
         det_reset <= 1'b0;
         lockout   <= 1'b0;
         retry_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (is_fault) begin
                  state     <= SHUTDOWN;
                  power_en  <= 1'b0;
                  retry_cnt <= retry_inc;
               end else if (is_warning) begin
                  state  <= DERATE;
                  derate <= 1'b1;
               end else if (stable_done) begin
                  retry_cnt <= '0;
               end
            end
            DERATE: begin
               if (is_fault) begin
                  state     <= SHUTDOWN;
                  power_en  <= 1'b0;
                  derate    <= 1'b0;
                  retry_cnt <= retry_inc;
               end else if (is_normal) begin
                  state  <= RUN;
                  derate <= 1'b0;
               end
            end
            SHUTDOWN: begin
               if (retry_cnt == RW'(MAX_RETRY)) begin
                  state   <= LOCKOUT;
                  lockout <= 1'b1;
               end else begin
                  state <= COOLDOWN;
               end
            end
            COOLDOWN: begin
               if (cool_done) begin
                  state     <= RETRY;
                  det_reset <= 1'b1;
               end
            end
            RETRY: begin
               if (hold_done) begin
                  state     <= RUN;
                  det_reset <= 1'b0;
                  power_en  <= 1'b1;
               end
            end
            LOCKOUT: begin
               if (sw_clear) begin
                  state     <= COOLDOWN;
                  lockout   <= 1'b0;
                  retry_cnt <= '0;
               end
            end
            default: begin
               state     <= RUN;
               power_en  <= 1'b1;
               derate    <= 1'b0;
               det_reset <= 1'b0;
               lockout   <= 1'b0;
            end
         endcase
      end
   end

   // Software mask writes land on the edge after the strobe, in any state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_reg <= '0;
      end else if (mask_wr_en) begin
         mask_reg <= mask_wr_data;
      end
   end

`ifdef FAULT_LOG_EN
   // Sticky cause log: unmasked flags OR-ed in on each shutdown entry; sw_clear wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault_log <= '0;
      end else if (sw_clear) begin
         fault_log <= '0;
      end else if (shutdown_entry) begin
         fault_log <= fault_log | (fault_flags & ~mask_reg);
      end
   end
`else
   logic unused_log_inputs;
   assign unused_log_inputs = ^{fault_flags, shutdown_entry};
   assign fault_log         = 4'b0000;
`endif

endmodule
